sph_axil_regbank: RTL
=====================

SPH_AXIL_REGBANK -- requirements
Module: sph_axil_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI data width; legal values 32 or 64.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; power of two, 4..256.
REQ-003 SHALL have parameter AXI_ADDR_W, default 12, AXI address width; at least clog2(NUM_REGS)+clog2(DATA_W/8).
REQ-004 SHALL have parameter RO_MASK, default 0, NUM_REGS-bit mask; bit i set makes register i read-only, reading status_in slice i.
REQ-005 SHALL have ports ACLK in 1 (clock) and ARESETN in 1 (reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have AXI4-Lite write ports: awaddr in AXI_ADDR_W, awvalid in 1, awready out 1, wdata in DATA_W, wstrb in DATA_W/8, wvalid in 1, wready out 1, bresp out 2, bvalid out 1, bready in 1.
REQ-007 SHALL have AXI4-Lite read ports: araddr in AXI_ADDR_W, arvalid in 1, arready out 1, rdata out DATA_W, rresp out 2, rvalid out 1, rready in 1.
REQ-008 SHALL have reg_out out NUM_REGS*DATA_W (all RW registers, flattened), status_in in NUM_REGS*DATA_W (RO sources), wr_pulse out NUM_REGS (one-cycle pulse per successful write).

Function
REQ-009 SHALL decode word index = addr[clog2(DATA_W/8) +: clog2(NUM_REGS)]; byte-offset bits ignored.
REQ-010 SHALL return SLVERR (2'b10) when any address bit above the index field is nonzero; write discarded, rdata = 0.
REQ-011 SHALL return SLVERR on a write to an RO_MASK register; no state change, no wr_pulse.
REQ-012 Write FSM SHALL use states WR_IDLE -> WR_ACCEPT (when awvalid && wvalid) -> WR_RESP -> WR_IDLE (when bready); awvalid alone or wvalid alone SHALL not leave WR_IDLE.
REQ-013 In WR_ACCEPT, awready and wready SHALL both be high for exactly one cycle; register update and wr_pulse occur on that same edge.
REQ-014 Write SHALL honour wstrb per byte; byte k updates only when wstrb[k]=1; wstrb=0 still returns OKAY and pulses wr_pulse.
REQ-015 bvalid SHALL rise two cycles after awvalid&&wvalid are first seen in WR_IDLE and hold, with bresp stable, until bready.
REQ-016 Read FSM SHALL use states RD_IDLE -> RD_ACCEPT (when arvalid) -> RD_DATA -> RD_IDLE (when rready); arready high one cycle in RD_ACCEPT; rdata captured there.
REQ-017 rdata/rresp SHALL stay stable while rvalid && !rready.
REQ-018 Read and write FSMs SHALL run independently; a read capturing on the same edge a write updates the same register SHALL return the pre-write value.
REQ-019 RO registers SHALL return status_in sampled in RD_ACCEPT.

Reset
REQ-020 ARESETN low SHALL force both FSMs to idle and all outputs to 0: awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, wr_pulse, reg_out.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no response; the first handshake after release starts fresh.

Configuration
REQ-022 With SPH_REGBANK_IRQ_EN defined: ports irq_src in DATA_W and irq out 1 exist; register NUM_REGS-1 is W1C pending (bit set by irq_src bit, cleared by writing 1, set wins on the same cycle); irq = OR of pending bits, registered.
REQ-023 Without SPH_REGBANK_IRQ_EN: irq_src/irq absent; register NUM_REGS-1 is ordinary, governed by RO_MASK.

Structure
REQ-024 Package sph_regbank_pkg SHALL hold response constants (RESP_OKAY 2'b00, RESP_SLVERR 2'b10), the write-state and read-state enums, and the clog2 helper function.
REQ-025 Read mux plus read FSM SHALL be sub-module sph_regbank_rd_path; write logic stays in the top level.

Verification (DATA_W=32, NUM_REGS=8, AXI_ADDR_W=12, RO_MASK=8'h80)
REQ-026 Write 0x1..0x4 to 0x00,0x04,0x08,0x0C, then read back -> data equal, OKAY, bvalid two cycles after AW/W valid.
REQ-027 Write 0xAABBCCDD then 0x11223344 with wstrb=4'b0101 to 0x10 -> read 0xAA22CC44.
REQ-028 Write 0x100 -> SLVERR, no wr_pulse; write 0x1C, status_in slice 7 = 0xDEADBEEF -> SLVERR, read 0x1C returns 0xDEADBEEF OKAY.
REQ-029 Same-edge read/write of 0x08 (old 0x3, new 0x9) -> read returns 0x3; next read 0x9; bready/rready held low 5 cycles -> bvalid/rvalid, bresp/rresp, rdata stable throughout.
REQ-030 ARESETN low during WR_RESP -> bvalid drops immediately, all reg_out = 0; IRQ build: irq_src bit 3 pulse -> irq=1, write 0x8 to 0x1C -> irq=0.

Source files
------------

// File: rtl/sph_regbank_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite register bank.
package sph_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACCEPT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACCEPT = 2'd1,
        RD_DATA   = 2'd2
    } rd_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sph_axil_regbank_if.sv
// AXI4-Lite bus bundle between a master and the register bank.
interface sph_axil_regbank_if #(
    parameter int AXI_ADDR_W = 12,
    parameter int DATA_W     = 32
);
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sph_regbank_rd_path.sv
// Read channel of the register bank: address decode, read mux and read FSM.
module sph_regbank_rd_path
    import sph_regbank_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int AXI_ADDR_W = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXI_ADDR_W-1:0]      araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [NUM_REGS*DATA_W-1:0] rw_regs,
    input  logic [NUM_REGS*DATA_W-1:0] status_in
);
    localparam int OFF_W = clog2(DATA_W / 8);
    localparam int IDX_W = clog2(NUM_REGS);

    rd_state_e             rd_q, rd_d;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            rresp_q;
    logic [IDX_W-1:0]      ridx;
    logic                  rd_err;
    logic [DATA_W-1:0]     rd_word;

    assign ridx   = araddr[OFF_W +: IDX_W];
    assign rd_err = |(araddr >> (OFF_W + IDX_W));

    always_comb begin
        rd_word = rw_regs[ridx*DATA_W +: DATA_W];
        if (RO_MASK[ridx]) rd_word = status_in[ridx*DATA_W +: DATA_W];
    end

    always_comb begin
        rd_d = rd_q;
        case (rd_q)
            RD_IDLE:   if (arvalid) rd_d = RD_ACCEPT;
            RD_ACCEPT: rd_d = RD_DATA;
            RD_DATA:   if (rready) rd_d = RD_IDLE;
            default:   rd_d = RD_IDLE;
        endcase
    end

    // Data is captured on the accept edge, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= RD_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            rd_q <= rd_d;
            if (rd_q == RD_ACCEPT) begin
                rdata_q <= rd_err ? '0 : rd_word;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign arready = (rd_q == RD_ACCEPT);
    assign rvalid  = (rd_q == RD_DATA);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
endmodule

// File: rtl/sph_axil_regbank.sv
// AXI4-Lite register bank with RO status registers and byte-strobed writes.
// Optional SPH_REGBANK_IRQ_EN turns the last register into a W1C irq pending word.
module sph_axil_regbank
    import sph_regbank_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int AXI_ADDR_W = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    sph_axil_regbank_if.slave          axi,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [NUM_REGS*DATA_W-1:0] status_in,
    output logic [NUM_REGS-1:0]        wr_pulse
`ifdef SPH_REGBANK_IRQ_EN
    ,
    input  logic [DATA_W-1:0]          irq_src,
    output logic                       irq
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = clog2(STRB_W);
    localparam int IDX_W  = clog2(NUM_REGS);
    localparam int LAST   = NUM_REGS - 1;
    localparam logic [NUM_REGS-1:0] LAST_BIT = NUM_REGS'(1) << LAST;
`ifdef SPH_REGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [NUM_REGS-1:0] EFF_RO =
        IRQ_EN ? (RO_MASK & ~LAST_BIT) : RO_MASK;

    wr_state_e          wr_q, wr_d;
    logic [1:0]         bresp_q;
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [IDX_W-1:0]   widx;
    logic               wr_err;
    logic               wr_acc;
    logic               wr_do;
    logic [DATA_W-1:0]  bmask;

    assign widx   = axi.awaddr[OFF_W +: IDX_W];
    assign wr_err = (|(axi.awaddr >> (OFF_W + IDX_W))) | EFF_RO[widx];
    assign wr_acc = (wr_q == WR_ACCEPT);
    assign wr_do  = wr_acc & ~wr_err;

    always_comb begin
        bmask = '0;
        for (int k = 0; k < STRB_W; k++)
            bmask[k*8 +: 8] = {8{axi.wstrb[k]}};
    end

    always_comb begin
        wr_d = wr_q;
        case (wr_q)
            WR_IDLE:   if (axi.awvalid && axi.wvalid) wr_d = WR_ACCEPT;
            WR_ACCEPT: wr_d = WR_RESP;
            WR_RESP:   if (axi.bready) wr_d = WR_IDLE;
            default:   wr_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_q       <= WR_IDLE;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_q       <= wr_d;
            wr_pulse_q <= '0;
            if (wr_acc) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (wr_do) begin
                wr_pulse_q[widx] <= 1'b1;
                if (!(IRQ_EN && widx == IDX_W'(LAST)))
                    regs_q[widx] <= (regs_q[widx] & ~bmask)
                                  | (axi.wdata & bmask);
            end
        end
    end

    assign axi.awready = wr_acc;
    assign axi.wready  = wr_acc;
    assign axi.bvalid  = (wr_q == WR_RESP);
    assign axi.bresp   = bresp_q;
    assign wr_pulse    = wr_pulse_q;

`ifdef SPH_REGBANK_IRQ_EN
    logic [DATA_W-1:0] pend_q, pend_d, w1c;
    logic              irq_q;

    // A new source bit wins over a same-cycle clear.
    always_comb begin
        w1c = '0;
        if (wr_do && widx == IDX_W'(LAST)) w1c = axi.wdata & bmask;
        pend_d = (pend_q & ~w1c) | irq_src;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= |pend_d;
        end
    end

    assign irq = irq_q;
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
`ifdef SPH_REGBANK_IRQ_EN
        if (i == LAST) begin : g_pend
            assign reg_out[i*DATA_W +: DATA_W] = pend_q;
        end else begin : g_rw
            assign reg_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
`else
        assign reg_out[i*DATA_W +: DATA_W] = regs_q[i];
`endif
    end

    sph_regbank_rd_path #(
        .DATA_W     (DATA_W),
        .NUM_REGS   (NUM_REGS),
        .AXI_ADDR_W (AXI_ADDR_W),
        .RO_MASK    (EFF_RO)
    ) u_rd_path (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .araddr    (axi.araddr),
        .arvalid   (axi.arvalid),
        .arready   (axi.arready),
        .rdata     (axi.rdata),
        .rresp     (axi.rresp),
        .rvalid    (axi.rvalid),
        .rready    (axi.rready),
        .rw_regs   (reg_out),
        .status_in (status_in)
    );
endmodule
